// File: rtl/anb_rd_splitter.sv
// Read-request splitter: breaks a master burst into MAX_BURST-aligned sub-bursts and merges the returned data.
// Optional m_d register slice enabled by defining ANB_RD_SPLITTER_REG_SLICE_EN.
module anb_rd_splitter #(
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 16,
  parameter int DATA_W    = 256,
  parameter int MAX_BURST = 16,
  parameter int OUTST     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_a_avalid,
  output logic              m_a_aready,
  input  logic [ADDR_W-1:0] m_a_addr,
  input  logic [LEN_W-1:0]  m_a_len,
  output logic              s_a_avalid,
  input  logic              s_a_aready,
  output logic [ADDR_W-1:0] s_a_addr,
  output logic [LEN_W-1:0]  s_a_len,
  input  logic              s_d_valid,
  output logic              s_d_ready,
  input  logic [DATA_W-1:0] s_d_data,
  input  logic              s_d_last,
  output logic              m_d_valid,
  input  logic              m_d_ready,
  output logic [DATA_W-1:0] m_d_data,
  output logic              m_d_last
);

  localparam int OFS_W = $clog2(MAX_BURST);
  localparam int CNT_W = (LEN_W + 1 > OFS_W + 1) ? LEN_W + 1 : OFS_W + 1;
  localparam int PTR_W = (OUTST > 1) ? $clog2(OUTST) : 1;

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W:0]    remaining;
  logic [CNT_W-1:0]  rem_ext, room, sub_beats;
  logic              sub_final, m_a_fire, a_push, d_pop;

  logic [OUTST-1:0]  fin_q;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              fifo_full, fifo_empty, head_final;

  logic              md_valid_c, md_ready_c, md_last_c;

  // A sub-burst never crosses a MAX_BURST-aligned boundary.
  assign rem_ext   = CNT_W'(remaining);
  assign room      = CNT_W'(MAX_BURST) - CNT_W'(cur_addr[OFS_W-1:0]);
  assign sub_beats = (rem_ext < room) ? rem_ext : room;
  assign sub_final = (rem_ext == sub_beats);
  assign s_a_addr  = cur_addr;
  assign s_a_len   = LEN_W'(sub_beats - CNT_W'(1));

  assign m_a_aready = (state == IDLE) & rst;
  assign s_a_avalid = (state == SPLIT) & ~fifo_full;
  assign m_a_fire   = m_a_avalid & m_a_aready;
  assign a_push     = s_a_avalid & s_a_aready;
  assign d_pop      = s_d_valid & s_d_ready & s_d_last;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (m_a_fire) state_nxt = SPLIT;
      SPLIT:   if (a_push && sub_final) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
    end else begin
      state <= state_nxt;
      if (m_a_fire) begin
        cur_addr  <= m_a_addr;
        remaining <= (LEN_W+1)'(m_a_len) + (LEN_W+1)'(1);
      end else if (a_push) begin
        cur_addr  <= cur_addr + ADDR_W'(sub_beats);
        remaining <= remaining - (LEN_W+1)'(sub_beats);
      end
    end
  end

  // Tracking FIFO holds one "ends the master request" flag per issued sub-burst.
  assign fifo_full  = (count == (PTR_W+1)'(OUTST));
  assign fifo_empty = (count == '0);
  assign head_final = fin_q[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fin_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (a_push) begin
        fin_q[wr_ptr] <= sub_final;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (d_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (a_push && !d_pop) count <= count + (PTR_W+1)'(1);
      else if (!a_push && d_pop) count <= count - (PTR_W+1)'(1);
    end
  end

  assign md_valid_c = s_d_valid & ~fifo_empty;
  assign s_d_ready  = md_ready_c & ~fifo_empty;
  assign md_last_c  = s_d_last & head_final & ~fifo_empty;

`ifdef ANB_RD_SPLITTER_REG_SLICE_EN
  logic [DATA_W-1:0] rs_data [2];
  logic [1:0]        rs_last;
  logic [1:0]        rs_cnt;
  logic              rs_wp, rs_rp, rs_push, rs_pop;

  // Two entries let the input ready come from a register without losing throughput.
  assign md_ready_c = (rs_cnt != 2'd2);
  assign rs_push    = md_valid_c & md_ready_c;
  assign rs_pop     = m_d_valid & m_d_ready;
  assign m_d_valid  = (rs_cnt != 2'd0);
  assign m_d_data   = rs_data[rs_rp];
  assign m_d_last   = rs_last[rs_rp] & m_d_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs_cnt  <= '0;
      rs_wp   <= 1'b0;
      rs_rp   <= 1'b0;
      rs_last <= '0;
    end else begin
      if (rs_push) begin
        rs_last[rs_wp] <= md_last_c;
        rs_wp          <= ~rs_wp;
      end
      if (rs_pop) rs_rp <= ~rs_rp;
      if (rs_push && !rs_pop) rs_cnt <= rs_cnt + 2'd1;
      else if (!rs_push && rs_pop) rs_cnt <= rs_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rs_push) rs_data[rs_wp] <= s_d_data;
  end
`else
  assign md_ready_c = m_d_ready;
  assign m_d_valid  = md_valid_c;
  assign m_d_data   = s_d_data;
  assign m_d_last   = md_last_c;
`endif

endmodule

// File: tb/tb_anb_rd_splitter.sv
// Directed bench for anb_rd_splitter: a reference split model fills scoreboards of expected
// sub-requests and master beats; a slave model answers issued sub-bursts with address-tagged data.
module tb_anb_rd_splitter;

  localparam int ADDR_W    = 32;
  localparam int LEN_W     = 16;
  localparam int DATA_W    = 64;
  localparam int MAX_BURST = 16;
  localparam int OUTST     = 4;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] len;
    bit          fin;
  } sub_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              m_a_avalid, m_a_aready;
  logic [ADDR_W-1:0] m_a_addr;
  logic [LEN_W-1:0]  m_a_len;
  logic              s_a_avalid, s_a_aready;
  logic [ADDR_W-1:0] s_a_addr;
  logic [LEN_W-1:0]  s_a_len;
  logic              s_d_valid, s_d_ready, s_d_last;
  logic [DATA_W-1:0] s_d_data;
  logic              m_d_valid, m_d_ready, m_d_last;
  logic [DATA_W-1:0] m_d_data;

  int    errors = 0;
  int    checks = 0;
  sub_t  exp_sub[$];
  sub_t  slv_q[$];
  beat_t exp_beats[$];
  bit    busy = 0;
  bit    ma_seen = 0;
  bit    slave_en = 0;
  bit    slave_force = 0;
  int    idx = 0;
  int    sa_count = 0;
  int    md_count = 0;

  anb_rd_splitter #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .OUTST(OUTST)
  ) dut (
    .clk(clk), .rst(rst),
    .m_a_avalid(m_a_avalid), .m_a_aready(m_a_aready), .m_a_addr(m_a_addr), .m_a_len(m_a_len),
    .s_a_avalid(s_a_avalid), .s_a_aready(s_a_aready), .s_a_addr(s_a_addr), .s_a_len(s_a_len),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_data(s_d_data), .s_d_last(s_d_last),
    .m_d_valid(m_d_valid), .m_d_ready(m_d_ready), .m_d_data(m_d_data), .m_d_last(m_d_last)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] beat_data(input logic [31:0] a);
    return {32'h5A5A_A5A5, a};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check handshakes at the falling edge, then drive the slave just after the rising edge.
  task automatic tick();
    sub_t  s;
    beat_t b;
    bit    sa_hs, sd_hs, md_hs, ma_hs;
    @(negedge clk);
    sa_hs = s_a_avalid && s_a_aready;
    sd_hs = s_d_valid && s_d_ready;
    md_hs = m_d_valid && m_d_ready;
    ma_hs = m_a_avalid && m_a_aready;
    checkOutput("m_a_aready", 64'(m_a_aready), 64'(!busy));
    checkOutput("s_a_avalid", 64'(s_a_avalid), 64'(busy && slv_q.size() < OUTST));
    checkOutput("s_d_ready", 64'(s_d_ready), 64'(m_d_ready && slv_q.size() != 0));
    checkOutput("m_d_valid", 64'(m_d_valid), 64'(s_d_valid && slv_q.size() != 0));
    if (md_hs) begin
      if (exp_beats.size() == 0) checkOutput("md_unexpected_beat", 64'(1), 64'(0));
      else begin
        b = exp_beats.pop_front();
        checkOutput("m_d_data", m_d_data, b.data);
        checkOutput("m_d_last", 64'(m_d_last), 64'(b.last));
      end
      md_count++;
    end
    if (sd_hs) begin
      idx++;
      if (s_d_last) begin
        void'(slv_q.pop_front());
        idx = 0;
      end
    end
    if (sa_hs) begin
      if (exp_sub.size() == 0) checkOutput("sa_unexpected_req", 64'(1), 64'(0));
      else begin
        s = exp_sub.pop_front();
        checkOutput("s_a_addr", 64'(s_a_addr), 64'(s.addr));
        checkOutput("s_a_len", 64'(s_a_len), 64'(s.len));
        if (s.fin) busy = 0;
      end
      s.addr = s_a_addr;
      s.len  = s_a_len;
      slv_q.push_back(s);
      sa_count++;
    end
    if (ma_hs) begin
      busy    = 1;
      ma_seen = 1;
    end
    @(posedge clk);
    #1;
    if (slave_en && slv_q.size() != 0) begin
      s_d_valid = 1'b1;
      s_d_data  = beat_data(slv_q[0].addr + 32'(idx));
      s_d_last  = (idx == int'(slv_q[0].len));
    end else if (slave_force) begin
      s_d_valid = 1'b1;
      s_d_data  = '1;
      s_d_last  = 1'b1;
    end else begin
      s_d_valid = 1'b0;
      s_d_data  = '0;
      s_d_last  = 1'b0;
    end
  endtask

  // Push the expected split and beat stream, then present the request until accepted.
  task automatic applyStimulus(input logic [31:0] addr, input logic [15:0] len, input string tag);
    logic [31:0] cur;
    int          rem, room, sb, n;
    sub_t        s;
    beat_t       b;
    cur = addr;
    rem = int'(len) + 1;
    while (rem > 0) begin
      room   = MAX_BURST - int'(cur[3:0]);
      sb     = (rem < room) ? rem : room;
      s.addr = cur;
      s.len  = 16'(sb - 1);
      rem    = rem - sb;
      s.fin  = (rem == 0);
      exp_sub.push_back(s);
      cur    = cur + 32'(sb);
    end
    for (int i = 0; i <= int'(len); i++) begin
      b.data = beat_data(addr + 32'(i));
      b.last = (i == int'(len));
      exp_beats.push_back(b);
    end
    m_a_avalid = 1'b1;
    m_a_addr   = addr;
    m_a_len    = len;
    ma_seen    = 0;
    n          = 0;
    while (!ma_seen && n < 100) begin
      tick();
      n++;
    end
    checkOutput({tag, "_accept"}, 64'(ma_seen), 64'(1));
    m_a_avalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_beats.size() != 0 || exp_sub.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    checkOutput({tag, "_leftover"}, 64'(exp_beats.size() + exp_sub.size()), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_m_a_aready"}, 64'(m_a_aready), 64'(0));
    checkOutput({tag, "_s_a_avalid"}, 64'(s_a_avalid), 64'(0));
    checkOutput({tag, "_s_d_ready"}, 64'(s_d_ready), 64'(0));
    checkOutput({tag, "_m_d_valid"}, 64'(m_d_valid), 64'(0));
    checkOutput({tag, "_m_d_last"}, 64'(m_d_last), 64'(0));
  endtask

  initial begin
    int base, n;
    rst        = 1'b0;
    m_a_avalid = 1'b0;
    m_a_addr   = '0;
    m_a_len    = '0;
    s_a_aready = 1'b1;
    s_d_valid  = 1'b0;
    s_d_data   = '0;
    s_d_last   = 1'b0;
    m_d_ready  = 1'b1;
    #3;
    check_reset_outputs("por");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("post_reset_m_a_aready", 64'(m_a_aready), 64'(1));
    tick();

    // Aligned single sub-burst.
    slave_en = 1;
    applyStimulus(32'h100, 16'd15, "aligned");
    drain("aligned");

    // Misaligned start splits at the 16-beat boundary; first slave last is hidden.
    applyStimulus(32'h10C, 16'd9, "misaligned");
    drain("misaligned");

    // Tracking FIFO fills with data held off; fifth sub-request waits for a pop.
    slave_en = 0;
    base = sa_count;
    applyStimulus(32'h200, 16'd79, "fifo_full");
    repeat (20) tick();
    checkOutput("fifo_full_issued", 64'(sa_count - base), 64'(4));
    slave_en = 1;
    drain("fifo_full");

    // Master back-pressure mid-burst.
    base = md_count;
    applyStimulus(32'h400, 16'd9, "stall");
    n = 0;
    while (md_count - base < 4 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("stall_reach_beat4", 64'(md_count - base), 64'(4));
    m_d_ready = 1'b0;
    base = md_count;
    repeat (5) tick();
    checkOutput("stall_no_beats", 64'(md_count - base), 64'(0));
    m_d_ready = 1'b1;
    drain("stall");

    // Address wrap at the top of the address space.
    applyStimulus(32'hFFFF_FFFC, 16'd7, "wrap");
    drain("wrap");

    // Slave data with nothing issued must stall.
    slave_force = 1;
    repeat (3) tick();
    slave_force = 0;
    tick();

    // Second request accepted while the first one's data is still pending.
    slave_en = 0;
    applyStimulus(32'h500, 16'd3, "overlap_a");
    applyStimulus(32'h600, 16'd3, "overlap_b");
    slave_en = 1;
    drain("overlap");

    // Reset in the middle of a split after two sub-requests.
    slave_en = 0;
    base = sa_count;
    applyStimulus(32'h300, 16'd63, "midreset");
    n = 0;
    while (sa_count - base < 2 && n < 50) begin
      tick();
      n++;
    end
    s_a_aready = 1'b0;
    checkOutput("midreset_two_issued", 64'(sa_count - base), 64'(2));
    s_d_valid = 1'b1;
    s_d_data  = beat_data(32'h300);
    s_d_last  = 1'b0;
    #1;
    checkOutput("midreset_pre_s_a_avalid", 64'(s_a_avalid), 64'(1));
    checkOutput("midreset_pre_s_d_ready", 64'(s_d_ready), 64'(1));
    checkOutput("midreset_pre_m_d_data", m_d_data, beat_data(32'h300));
    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    s_d_valid = 1'b0;
    s_d_last  = 1'b0;
    s_a_aready = 1'b1;
    exp_sub.delete();
    exp_beats.delete();
    slv_q.delete();
    busy = 0;
    idx  = 0;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset_held");
    rst = 1'b1;
    slave_en = 1;
    tick();
    base = md_count;
    applyStimulus(32'h0, 16'd0, "after_reset");
    drain("after_reset");
    checkOutput("after_reset_beats", 64'(md_count - base), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
